mem_dma_arbiter: RTL and testbench

Shares the SBC6120/V memory bus (ax, ema, dx, mrd, mwr, cpmem) between the CPU and one data-break (DMA) requester, such as the SDRAM RAMdisk or a future disk controller. The block stalls the CPU at a safe point and runs a burst of single-cycle main-memory reads or writes with an auto-incrementing address. It forces a one-cycle CPU yield after every MAX_BURST accesses so the CPU is never starved. It sits between the CPU and the memory module; the memory module itself is unchanged.

---
 rtl/mem_dma_arbiter_pkg.sv | 18 +
 rtl/mem_dma_addrgen.sv | 47 ++++
 rtl/mem_dma_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_dma_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_arbiter_pkg.sv
// rtl/mem_dma_arbiter_pkg.sv - shared widths, defaults and state encoding for the DMA memory arbiter
// Contents: WORD/EMA bus widths, default burst limit, arbiter state enumeration.
package mem_dma_arbiter_pkg;

    localparam int WORD              = 12;
    localparam int EMA               = 3;
    localparam int DMA_MAX_BURST_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ACCESS,
        ST_YIELD,
        ST_WAIT,
        ST_DONE
    } dma_state_t;

endpackage

// File: rtl/mem_dma_addrgen.sv
// rtl/mem_dma_addrgen.sv - DMA address, field and remaining-length registers with increment and wrap
// Ports: clk/rst_n (async active-low); load latches start address, field and length;
//        step advances one word; addr/ema drive the memory bus; last flags the final word.
module mem_dma_addrgen
    import mem_dma_arbiter_pkg::*;
#(
    parameter bit FIELD_CARRY = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [WORD-1:0] load_addr,
    input  logic [EMA-1:0]  load_ema,
    input  logic [WORD-1:0] load_len,
    input  logic            step,
    output logic [WORD-1:0] addr,
    output logic [EMA-1:0]  ema,
    output logic            last
);

    // One extra bit so that a length of 0 can stand for a full 4096-word burst.
    logic [WORD:0] remain;
    logic [WORD:0] addr_inc;

    assign addr_inc = {1'b0, addr} + (WORD+1)'(1);
    assign last     = (remain == (WORD+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            ema    <= '0;
            remain <= '0;
        end else if (load) begin
            addr   <= load_addr;
            ema    <= load_ema;
            remain <= (load_len == '0) ? {1'b1, {WORD{1'b0}}} : {1'b0, load_len};
        end else if (step) begin
            addr   <= addr_inc[WORD-1:0];
            // Carry out of 7777 moves to the next field only when enabled; the field wraps 7->0.
            if (FIELD_CARRY && addr_inc[WORD]) begin
                ema <= ema + EMA'(1);
            end
            remain <= remain - (WORD+1)'(1);
        end
    end

endmodule

// File: rtl/mem_dma_arbiter.sv
// rtl/mem_dma_arbiter.sv - shares the memory bus between the CPU and one data-break burst requester
// Ports: cpuclk/reset_n (async active-low); cpu_* CPU bus side with cpu_safe/cpu_hold handshake;
//        dma_* requester side (req/wr/addr/ema/len/wdata in, wstb/rdata/rvalid/done out);
//        mem_* to the memory module; dx shared data bus, driven here only while writing.
module mem_dma_arbiter
    import mem_dma_arbiter_pkg::*;
#(
    parameter int MAX_BURST   = DMA_MAX_BURST_DEF,
    parameter bit FIELD_CARRY = 1'b0
) (
    input  logic            cpuclk,
    input  logic            reset_n,
    input  logic [WORD-1:0] cpu_ax,
    input  logic [EMA-1:0]  cpu_ema,
    input  logic            cpu_mrd,
    input  logic            cpu_mwr,
    input  logic            cpu_cpmem,
    input  logic            cpu_safe,
    output logic            cpu_hold,
    input  logic            dma_req,
    input  logic            dma_wr,
    input  logic [WORD-1:0] dma_addr,
    input  logic [EMA-1:0]  dma_ema,
    input  logic [WORD-1:0] dma_len,
    input  logic [WORD-1:0] dma_wdata,
    output logic            dma_wstb,
    output logic [WORD-1:0] dma_rdata,
    output logic            dma_rvalid,
    output logic            dma_done,
    output logic [WORD-1:0] mem_ax,
    output logic [EMA-1:0]  mem_ema,
    output logic            mem_mrd,
    output logic            mem_mwr,
    output logic            mem_cpmem,
    inout  wire  [WORD-1:0] dx
);

    dma_state_t      state;
    logic            wr_q;
    logic            armed;
    logic [6:0]      burst_cnt;
    logic            load;
    logic            step;
    logic            last;
    logic [WORD-1:0] dma_ax;
    logic [EMA-1:0]  dma_field;

    // A request level left high after a completed burst must be seen low before it counts again.
    assign load = (state == ST_IDLE) && dma_req && armed && cpu_safe;
    assign step = (state == ST_ACCESS);

    mem_dma_addrgen #(
        .FIELD_CARRY (FIELD_CARRY)
    ) u_addrgen (
        .clk       (cpuclk),
        .rst_n     (reset_n),
        .load      (load),
        .load_addr (dma_addr),
        .load_ema  (dma_ema),
        .load_len  (dma_len),
        .step      (step),
        .addr      (dma_ax),
        .ema       (dma_field),
        .last      (last)
    );

    assign mem_ax    = cpu_hold ? dma_ax    : cpu_ax;
    assign mem_ema   = cpu_hold ? dma_field : cpu_ema;
    assign mem_mrd   = cpu_hold ? (step && !wr_q) : cpu_mrd;
    assign mem_mwr   = cpu_hold ? (step &&  wr_q) : cpu_mwr;
    assign mem_cpmem = cpu_hold ? 1'b0 : cpu_cpmem;
    assign dx        = (step && wr_q) ? dma_wdata : {WORD{1'bz}};

    always_ff @(posedge cpuclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cpu_hold   <= 1'b0;
            wr_q       <= 1'b0;
            armed      <= 1'b1;
            burst_cnt  <= '0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_wstb   <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            dma_rvalid <= 1'b0;
            dma_wstb   <= 1'b0;
            dma_done   <= 1'b0;

            if (!dma_req) begin
                armed <= 1'b1;
            end else if (state == ST_DONE) begin
                armed <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (load) begin
                        wr_q      <= dma_wr;
                        burst_cnt <= '0;
                        cpu_hold  <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (wr_q) begin
                        dma_wstb <= 1'b1;
                    end else begin
                        dma_rdata  <= dx;
                        dma_rvalid <= 1'b1;
                    end
                    burst_cnt <= burst_cnt + 7'd1;
                    if (last) begin
                        cpu_hold <= 1'b0;
                        dma_done <= 1'b1;
                        state    <= ST_DONE;
                    end else if (!dma_req) begin
                        cpu_hold <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (burst_cnt + 7'd1 == 7'(MAX_BURST)) begin
                        cpu_hold <= 1'b0;
                        state    <= ST_YIELD;
                    end
                end
                // The yield cycle is the first cycle of the wait: the CPU owns the bus for it
                // unconditionally, and a safe point at its end lets the burst resume with a
                // single-cycle gap.
                ST_YIELD, ST_WAIT: begin
                    if (!dma_req) begin
                        state <= ST_IDLE;
                    end else if (cpu_safe) begin
                        cpu_hold  <= 1'b1;
                        burst_cnt <= '0;
                        state     <= ST_GRANT;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dma_arbiter.sv
// tb/tb_mem_dma_arbiter.sv - self-checking bench for mem_dma_arbiter
module tb_mem_dma_arbiter;

    logic        cpuclk = 1'b0;
    logic        reset_n;
    logic [11:0] cpu_ax;
    logic [2:0]  cpu_ema;
    logic        cpu_mrd, cpu_mwr, cpu_cpmem, cpu_safe;
    logic        dma_req, dma_wr;
    logic [11:0] dma_addr, dma_len, dma_wdata;
    logic [2:0]  dma_ema;

    logic        cpu_hold0, dma_wstb0, dma_rvalid0, dma_done0, mem_mrd0, mem_mwr0, mem_cpmem0;
    logic [11:0] dma_rdata0, mem_ax0;
    logic [2:0]  mem_ema0;
    wire  [11:0] dx0;
    logic        cpu_hold1, dma_wstb1, dma_rvalid1, dma_done1, mem_mrd1, mem_mwr1, mem_cpmem1;
    logic [11:0] dma_rdata1, mem_ax1;
    logic [2:0]  mem_ema1;
    wire  [11:0] dx1;

    logic [11:0] mem [0:32767];
    logic        init_req;
    logic        tb_zero;
    logic [11:0] wbuf [0:63];
    int          widx;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [14:0] last_loc0, last_loc1;
    int          eps_out;

    always #5 cpuclk = ~cpuclk;

    mem_dma_arbiter #(.MAX_BURST(8), .FIELD_CARRY(1'b0)) u_dut0 (
        .cpuclk(cpuclk), .reset_n(reset_n), .cpu_ax(cpu_ax), .cpu_ema(cpu_ema),
        .cpu_mrd(cpu_mrd), .cpu_mwr(cpu_mwr), .cpu_cpmem(cpu_cpmem), .cpu_safe(cpu_safe),
        .cpu_hold(cpu_hold0), .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
        .dma_ema(dma_ema), .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_wstb(dma_wstb0),
        .dma_rdata(dma_rdata0), .dma_rvalid(dma_rvalid0), .dma_done(dma_done0),
        .mem_ax(mem_ax0), .mem_ema(mem_ema0), .mem_mrd(mem_mrd0), .mem_mwr(mem_mwr0),
        .mem_cpmem(mem_cpmem0), .dx(dx0));

    mem_dma_arbiter #(.MAX_BURST(8), .FIELD_CARRY(1'b1)) u_dut1 (
        .cpuclk(cpuclk), .reset_n(reset_n), .cpu_ax(cpu_ax), .cpu_ema(cpu_ema),
        .cpu_mrd(cpu_mrd), .cpu_mwr(cpu_mwr), .cpu_cpmem(cpu_cpmem), .cpu_safe(cpu_safe),
        .cpu_hold(cpu_hold1), .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
        .dma_ema(dma_ema), .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_wstb(dma_wstb1),
        .dma_rdata(dma_rdata1), .dma_rvalid(dma_rvalid1), .dma_done(dma_done1),
        .mem_ax(mem_ax1), .mem_ema(mem_ema1), .mem_mrd(mem_mrd1), .mem_mwr(mem_mwr1),
        .mem_cpmem(mem_cpmem1), .dx(dx1));

    // Memory model: 8 fields x 4096 words; only the FIELD_CARRY=0 instance writes it.
    assign dx0 = mem_mrd0 ? mem[{mem_ema0, mem_ax0}] : (tb_zero ? 12'd0 : 12'bz);
    assign dx1 = mem_mrd1 ? mem[{mem_ema1, mem_ax1}] : 12'bz;

    always @(posedge cpuclk) begin
        if (init_req) begin
            for (int i = 0; i < 32768; i++) mem[i] <= 12'((i * 37 + 5) ^ (i >> 3));
        end else if (mem_mwr0 && !mem_cpmem0) begin
            mem[{mem_ema0, mem_ax0}] <= dx0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference location of the i-th word of a burst: plain arithmetic on a flat address.
    function automatic logic [14:0] exp_loc(input logic [11:0] a, input logic [2:0] e,
                                            input int i, input bit fc);
        int flat;
        logic [2:0] f;
        flat = int'(a) + i;
        f = fc ? 3'((int'(e) + flat / 4096) % 8) : e;
        return {f, 12'(flat % 4096)};
    endfunction

    task automatic step();
        @(negedge cpuclk);
        if (dma_wstb0) widx++;
        dma_wdata = wbuf[widx % 64];
        #1;
    endtask

    task automatic run_burst(input bit wr, input logic [11:0] a, input logic [2:0] e,
                             input logic [11:0] len, input bit rnd_safe, input bit use_wd,
                             input logic [11:0] wd0, input logic [11:0] wd1);
        int n = (len == 12'd0) ? 4096 : int'(len);
        int acc0 = 0, acc1 = 0, rv0 = 0, rv1 = 0, ws = 0, gap = 0, eps = 0, cyc = 0;
        bit started = 0, prev_hold = 0, fin = 0;
        for (int i = 0; i < 64; i++) wbuf[i] = 12'($urandom);
        if (use_wd) begin
            wbuf[0] = wd0;
            wbuf[1] = wd1;
        end
        widx = 0;
        dma_wdata = wbuf[0];
        dma_wr = wr; dma_addr = a; dma_ema = e; dma_len = len;
        cpu_mrd = 1'b1; cpu_ax = 12'o7070; cpu_ema = 3'd1; cpu_cpmem = 1'b1;
        cpu_safe = rnd_safe ? 1'($urandom) : 1'b1;
        dma_req = 1'b1;
        while (!fin && cyc < 20000) begin
            step();
            cyc++;
            if (cpu_hold0 && !prev_hold) begin
                started = 1;
                check("grant_no_strobe", {mem_mrd0, mem_mwr0}, 2'b00);
            end
            if (cpu_hold0 && (mem_mrd0 || mem_mwr0)) begin
                check("acc_loc0", {mem_ema0, mem_ax0}, exp_loc(a, e, acc0, 0));
                check("acc_type", {mem_mwr0, mem_mrd0}, {wr, !wr});
                check("acc_cpmem", mem_cpmem0, 0);
                if (wr) check("acc_wdata", dx0, wbuf[acc0 % 64]);
                last_loc0 = {mem_ema0, mem_ax0};
                acc0++;
            end
            if (cpu_hold1 && (mem_mrd1 || mem_mwr1)) begin
                check("acc_loc1", {mem_ema1, mem_ax1}, exp_loc(a, e, acc1, 1));
                last_loc1 = {mem_ema1, mem_ax1};
                acc1++;
            end
            if (dma_rvalid0) begin
                check("rdata0", dma_rdata0, mem[exp_loc(a, e, rv0, 0)]);
                rv0++;
            end
            if (dma_rvalid1) begin
                check("rdata1", dma_rdata1, mem[exp_loc(a, e, rv1, 1)]);
                rv1++;
            end
            if (dma_wstb0) ws++;
            if (started && !cpu_hold0 && !dma_done0) begin
                gap++;
                if (prev_hold) eps++;
                check("yield_passthru", {mem_mrd0, mem_cpmem0, mem_ax0}, {1'b1, 1'b1, 12'o7070});
            end
            if (dma_done0) fin = 1;
            prev_hold = cpu_hold0;
            if (rnd_safe) cpu_safe = 1'($urandom);
        end
        dma_req = 1'b0;
        cpu_mrd = 1'b0;
        cpu_safe = 1'b1;
        check("burst_done", fin, 1);
        check("acc_count0", acc0, n);
        check("acc_count1", acc1, n);
        check("rvalid_count0", rv0, wr ? 0 : n);
        check("rvalid_count1", rv1, wr ? 0 : n);
        check("wstb_count", ws, wr ? n : 0);
        check("yield_episodes", eps, (n - 1) / 8);
        if (!rnd_safe) check("yield_cycles", gap, (n - 1) / 8);
        eps_out = eps;
        step();
        check("hold_after_done", cpu_hold0, 0);
        check("done_one_cycle", dma_done0, 0);
        if (wr) begin
            cpu_cpmem = 1'b0;
            for (int i = 0; i < n; i++) begin
                {cpu_ema, cpu_ax} = exp_loc(a, e, i, 0);
                cpu_mrd = 1'b1;
                step();
                check("cpu_readback", dx0, wbuf[i % 64]);
            end
            cpu_mrd = 1'b0;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [2:0]  ema;
        logic [11:0] len;
        logic [11:0] wd0, wd1;
        logic [11:0] last_ax;
        logic [2:0]  last_ema0, last_ema1;
        int          yields;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int acc, rv, dn, c, rose;
        vecs[0] = '{1'b0, 12'o0100, 3'd2, 12'd3,  12'o0000, 12'o0000, 12'o0102, 3'd2, 3'd2, 0};
        vecs[1] = '{1'b1, 12'o0200, 3'd0, 12'd2,  12'o1234, 12'o4321, 12'o0201, 3'd0, 3'd0, 0};
        vecs[2] = '{1'b0, 12'o7776, 3'd5, 12'd4,  12'o0000, 12'o0000, 12'o0001, 3'd5, 3'd6, 0};
        vecs[3] = '{1'b0, 12'o1000, 3'd3, 12'd20, 12'o0000, 12'o0000, 12'o1023, 3'd3, 3'd3, 2};
        vecs[4] = '{1'b1, 12'o7774, 3'd7, 12'd9,  12'o0000, 12'o0000, 12'o0004, 3'd7, 3'd0, 1};

        reset_n = 1'b0; init_req = 1'b1; tb_zero = 1'b0; widx = 0;
        cpu_ax = 12'o1357; cpu_ema = 3'd3; cpu_mrd = 1'b0; cpu_mwr = 1'b0; cpu_cpmem = 1'b1;
        cpu_safe = 1'b1; dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_ema = '0;
        dma_len = '0; dma_wdata = '0;
        for (int i = 0; i < 64; i++) wbuf[i] = '0;
        repeat (2) @(posedge cpuclk);
        @(negedge cpuclk);
        init_req = 1'b0; reset_n = 1'b1; tb_zero = 1'b1;
        #1;
        check("rst_hold", cpu_hold0, 0);
        check("rst_strobes", {dma_wstb0, dma_rvalid0, dma_done0}, 3'b000);
        check("rst_rdata", dma_rdata0, 0);
        check("rst_dx_released", dx0, 0);
        check("rst_passthru", {mem_cpmem0, mem_ema0, mem_ax0}, {1'b1, 3'd3, 12'o1357});
        tb_zero = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_burst(vecs[v].wr, vecs[v].addr, vecs[v].ema, vecs[v].len, 1'b0, 1'b1,
                      vecs[v].wd0, vecs[v].wd1);
            check("vec_last_loc0", last_loc0, {vecs[v].last_ema0, vecs[v].last_ax});
            check("vec_last_loc1", last_loc1, {vecs[v].last_ema1, vecs[v].last_ax});
            check("vec_yields", eps_out, vecs[v].yields);
        end

        // Abort: request drops during the 2nd access; that access still completes.
        dma_wr = 1'b0; dma_addr = 12'o0300; dma_ema = 3'd1; dma_len = 12'd10;
        cpu_mrd = 1'b0; dma_req = 1'b1; acc = 0; rv = 0; dn = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dma_rvalid0) rv++;
            if (dma_done0) dn++;
            if (cpu_hold0 && mem_mrd0) begin
                acc++;
                if (acc == 2) dma_req = 1'b0;
            end
        end
        check("abort_accesses", acc, 2);
        check("abort_rvalids", rv, 2);
        check("abort_no_done", dn, 0);
        check("abort_hold_released", cpu_hold0, 0);

        // A level left high after done is ignored until seen low.
        dma_addr = 12'o0400; dma_len = 12'd1; dma_req = 1'b1; c = 0; rose = 0;
        while (!dma_done0 && c < 20) begin step(); c++; end
        check("rearm_first_done", dma_done0, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_hold0) rose++;
        end
        check("rearm_level_ignored", rose, 0);
        dma_req = 1'b0; step(); dma_req = 1'b1; c = 0;
        while (!cpu_hold0 && c < 5) begin step(); c++; end
        check("rearm_restart", cpu_hold0, 1);
        c = 0;
        while (!dma_done0 && c < 20) begin step(); c++; end
        check("rearm_second_done", dma_done0, 1);
        dma_req = 1'b0; step();

        for (int r = 0; r < 6; r++) begin
            run_burst(1'($urandom), 12'($urandom), 3'($urandom), 12'($urandom_range(1, 40)),
                      1'b1, 1'b0, 12'd0, 12'd0);
        end

        // Reset in the middle of a write burst.
        for (int i = 0; i < 64; i++) wbuf[i] = 12'o7777;
        widx = 0;
        dma_wr = 1'b1; dma_addr = 12'o0500; dma_ema = 3'd2; dma_len = 12'd10;
        dma_wdata = 12'o7777; cpu_mrd = 1'b0; cpu_ax = 12'o6543; cpu_ema = 3'd6;
        cpu_cpmem = 1'b1; dma_req = 1'b1; acc = 0; c = 0;
        while (acc < 3 && c < 40) begin
            step(); c++;
            if (cpu_hold0 && mem_mwr0) acc++;
        end
        check("rst_mid_reached", acc, 3);
        reset_n = 1'b0; tb_zero = 1'b1;
        #1;
        check("rst_mid_hold", cpu_hold0, 0);
        check("rst_mid_strobes", {dma_wstb0, dma_rvalid0, dma_done0}, 3'b000);
        check("rst_mid_rdata", dma_rdata0, 0);
        check("rst_mid_dx", dx0, 0);
        check("rst_mid_passthru", {mem_mwr0, mem_cpmem0, mem_ema0, mem_ax0},
              {1'b0, 1'b1, 3'd6, 12'o6543});
        dma_req = 1'b0;
        step();
        reset_n = 1'b1; tb_zero = 1'b0;
        step();

        run_burst(1'b0, 12'o0005, 3'd4, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
        check("full_len_last_loc0", last_loc0, {3'd4, 12'o0004});
        check("full_len_last_loc1", last_loc1, {3'd5, 12'o0004});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
